uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin, frame-granular arbiter that shares the single AXI-Stream transmit input of the `uart` block between `NUM_SRC` producers, such as the attitude-frame packer and the debug/register dump. A granted source keeps the UART until its `tlast` beat is accepted, so frames are never interleaved on the wire. A beat counter force-releases a source that exceeds `MAX_FRAME` beats. An optional header byte tags each frame with its source ID.

## Interface
- `NUM_SRC`, 2: number of requesters; legal range 2..4.
- `DATA_WIDTH`, 8: byte width; must match the `uart` `DATA_WIDTH`.
- `MAX_FRAME`, 64: maximum number of payload beats per grant; legal range 2..255.
- `clk_in`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  `NUM_SRC*DATA_WIDTH`  packed source data; source i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid`  in  `NUM_SRC`  per-source valid.
- `s_axis_tlast`  in  `NUM_SRC`  per-source end-of-frame.
- `s_axis_tready`  out  `NUM_SRC`  per-source ready.
- `m_axis_tdata`  out  `DATA_WIDTH`  data to the `uart` `s_axis_tdata`.
- `m_axis_tvalid`  out  1  valid to the `uart` `s_axis_tvalid`.
- `m_axis_tready`  in  1  ready from the `uart` `s_axis_tready`.
- `grant_id`  out  `clog2(NUM_SRC)`  index of the current or most recent grantee.
- `busy`  out  1  high while any frame is owned.
- `err_overlen`  out  1  one-cycle pulse when a frame is force-released.

## Operation
- The FSM has three states: IDLE, HDR, and PASS. HDR exists only when the header macro is defined.
- **IDLE**
  - All `s_axis_tready` and `m_axis_tvalid` are 0.
  - If any `s_axis_tvalid` is set, select the first set bit searching upward from `last_grant+1`, wrapping modulo `NUM_SRC`.
  - Register the selected index into `grant_id`, clear `beat_cnt`, and go to HDR, or to PASS when the header is disabled.
- **HDR**
  - `m_axis_tvalid`=1 and `m_axis_tdata`=`8'hA0 | grant_id`. All `s_axis_tready` are 0.
  - On `m_axis_tready`, go to PASS.
- **PASS**
  - Combinational forwarding: `m_axis_tdata`/`m_axis_tvalid` come from source `grant_id`.
  - `s_axis_tready[grant_id]`=`m_axis_tready`; every other ready is 0.
  - Each accepted beat (valid&ready) increments `beat_cnt`, which is 8 bits and saturating.
  - Accepted beat with `tlast`=1: set `last_grant`=`grant_id` and go to IDLE.
  - Accepted beat without `tlast` while `beat_cnt`==`MAX_FRAME-1`: pulse `err_overlen`, set `last_grant`=`grant_id`, and go to IDLE. The source's remaining beats re-arbitrate as a new frame.
- `busy` = (state != IDLE).
- While granted, a source may drop `tvalid` mid-frame. The grant is held indefinitely; bubbles are passed through.
- Requests arriving from other sources during a frame only affect the next arbitration.

## Timing
- **Reset values:** state=IDLE, `grant_id`=0, `last_grant`=`NUM_SRC-1` (source 0 wins first), `beat_cnt`=0. All outputs are 0.
- **Grant latency:** a request seen in IDLE at cycle N gives `m_axis_tvalid`=1 at cycle N+1, carrying the header or first payload byte.
- **Inter-frame gap:** exactly one IDLE cycle follows every frame end. Back-to-back frames therefore cost one bubble.
- **Throughput:** one beat per cycle whenever `m_axis_tready`=1. The UART itself throttles to one byte per character time.
- **Reset mid-frame:** `rst` wins over all transitions. The next cycle is IDLE with readies deasserted; the partial frame is abandoned.
- **Stable outputs:** `m_axis_tdata` and `m_axis_tvalid` change only on `clk_in` edges or via the combinational PASS mux. The mux select, `grant_id`, is registered.

## Configuration
- `UART_ARB_HEADER_EN` defined:
  - The HDR state is compiled in.
  - Every frame is prefixed with `8'hA0 | grant_id`.
  - Latency to the first payload byte is the grant cycle plus one header handshake.
  - The header does not count toward `MAX_FRAME`.
- `UART_ARB_HEADER_EN` undefined:
  - No HDR state exists; IDLE goes directly to PASS.
  - The output byte stream is exactly the concatenation of the source frames.

## Test plan
- **Single source, header off:** src0 sends 3 bytes 0x11,0x22,0x33 (`tlast` on 0x33) with `m_axis_tready`=1.
  - Required: `m_axis` carries 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after `tvalid`.
  - Required: `busy` is high for 3 cycles, then low for 1 IDLE cycle.
- **Round-robin, NUM_SRC=3:** all three sources continuously offer 2-byte frames.
  - Required: grant order is 0,1,2,0,1,2.
  - Required: frames never interleave.
  - Required: there is exactly 1 idle cycle between frames.
- **Backpressure:** `m_axis_tready` toggles 1,0,1,0 during a 4-byte frame from src1.
  - Required: bytes appear in order, and `s_axis_tready[1]` mirrors `m_axis_tready`.
  - Required: `s_axis_tready[0]` stays 0 throughout.
- **Overlength, MAX_FRAME=4:** src0 sends 6 bytes with `tlast` only on byte 6, and src1 is requesting.
  - Required: `err_overlen` pulses on acceptance of byte 4.
  - Required: src1's frame follows, then src0's bytes 5–6 as a new frame.
- **Header enabled:** src2 sends 0x7F with `tlast`.
  - Required: `m_axis` carries 0xA2 then 0x7F, and `grant_id`=2.
- **Reset mid-frame:** assert `rst` for 1 cycle after byte 2 of a 5-byte frame.
  - Required: the next cycle has all outputs 0 and the FSM in IDLE.
  - Required: the next grant goes to src0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing the uart AXI-Stream TX input between NUM_SRC producers.
// Optional macro UART_ARB_HEADER_EN prefixes each frame with a source-ID header byte (8'hA0 | grant_id).
//
// state | meaning
// IDLE  | no owner; pick the next requester searching upward from last_grant+1
// HDR   | header byte 8'hA0|grant_id offered downstream (UART_ARB_HEADER_EN only)
// PASS  | granted source forwarded until its tlast or MAX_FRAME beats

module uart_tx_arbiter #(
   parameter int NUM_SRC    = 2,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_FRAME  = 64
) (
   input  logic                          clk_in,
   input  logic                          rst,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [$clog2(NUM_SRC)-1:0]    grant_id,
   output logic                          busy,
   output logic                          err_overlen
);

   localparam int IDW = $clog2(NUM_SRC);
   localparam int SW  = IDW + 1;
   localparam logic [7:0] BEAT_LAST = 8'(MAX_FRAME - 1);

`ifdef UART_ARB_HEADER_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_PASS = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PASS = 2'd2} state_t;
`endif

   state_t         state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic [IDW-1:0] last_grant_q, last_grant_d;
   logic [7:0]     beat_cnt_q, beat_cnt_d;

   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  req_found;
   logic [IDW-1:0]        req_idx;

`ifdef UART_ARB_HEADER_EN
   logic [DATA_WIDTH-1:0] hdr_byte;
   assign hdr_byte = DATA_WIDTH'(8'hA0) | DATA_WIDTH'(grant_q);
`endif

   // base + step folded into 0..NUM_SRC-1; the sum never reaches 2*NUM_SRC
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int step);
      logic [SW-1:0] sum;
      sum = {1'b0, base} + SW'(step);
      if (sum >= SW'(NUM_SRC)) sum = sum - SW'(NUM_SRC);
      return sum[IDW-1:0];
   endfunction

   always_comb begin : src_mux
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == IDW'(i)) begin
            sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
         end
      end
   end

   always_comb begin : rr_pick
      req_found = 1'b0;
      req_idx   = last_grant_q;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (!req_found && s_axis_tvalid[rr_index(last_grant_q, k)]) begin
            req_found = 1'b1;
            req_idx   = rr_index(last_grant_q, k);
         end
      end
   end

   always_comb begin : fsm
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      beat_cnt_d    = beat_cnt_q;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      s_axis_tready = '0;
      err_overlen   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_found) begin
               grant_d    = req_idx;
               beat_cnt_d = '0;
`ifdef UART_ARB_HEADER_EN
               state_d    = ST_HDR;
`else
               state_d    = ST_PASS;
`endif
            end
         end
`ifdef UART_ARB_HEADER_EN
         ST_HDR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = hdr_byte;
            if (m_axis_tready) state_d = ST_PASS;
         end
`endif
         ST_PASS: begin
            m_axis_tvalid = sel_valid;
            m_axis_tdata  = sel_data;
            for (int i = 0; i < NUM_SRC; i++) begin
               s_axis_tready[i] = (grant_q == IDW'(i)) && m_axis_tready;
            end
            if (sel_valid && m_axis_tready) begin
               if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
               if (sel_last) begin
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end else if (beat_cnt_q == BEAT_LAST) begin
                  // force release; the rest of this frame re-arbitrates as a new one
                  err_overlen  = 1'b1;
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDW'(NUM_SRC - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (NUM_SRC=3, MAX_FRAME=4); header bytes are
// expected whenever UART_ARB_HEADER_EN is defined for the build.
module tb_uart_tx_arbiter;
   localparam int NS = 3;
   localparam int DW = 8;
   localparam int MF = 4;
`ifdef UART_ARB_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif

   typedef struct { logic [1:0] gid; logic [7:0] data; bit first; bit err; } exp_t;
   typedef struct { int cyc; logic [1:0] gid; logic [7:0] data; logic err; } obs_t;

   logic             clk_in;
   logic             rst;
   logic [NS*DW-1:0] s_tdata;
   logic [NS-1:0]    s_tvalid, s_tlast, s_tready;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid, m_tready;
   logic [1:0]       grant_id;
   logic             busy, err_overlen;

   int          tests, failed, cyc, err_total;
   logic [NS-1:0] fire;
   logic [8:0]  src_q [NS][$];
   exp_t        exp_q [$];
   obs_t        obs_q [$];
   logic        busy_tr [$];

   uart_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_FRAME(MF)) dut (
      .clk_in(clk_in), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .grant_id(grant_id), .busy(busy), .err_overlen(err_overlen)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One cycle: retire last cycle's handshakes, present source heads, then sample.
   task automatic step(input logic rdy, input logic rst_v);
      @(negedge clk_in);
      for (int i = 0; i < NS; i++)
         if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      rst = rst_v;
      m_tready = rdy;
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() > 0) begin
            s_tvalid[i] = 1'b1;
            s_tlast[i]  = src_q[i][0][8];
            s_tdata[i*DW +: DW] = src_q[i][0][7:0];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            s_tdata[i*DW +: DW] = '0;
         end
      end
      #1;
      cyc++;
      if (rst_v) fire = '0;
      else begin
         fire = s_tvalid & s_tready;
         busy_tr.push_back(busy);
         if (err_overlen) err_total++;
         if (m_tvalid && m_tready)
            obs_q.push_back('{cyc: cyc, gid: grant_id, data: m_tdata, err: err_overlen});
      end
   endtask

   function automatic void load(input int src, input logic [7:0] d, input bit last);
      src_q[src].push_back({last, d});
   endfunction

   function automatic void exp_beat(input int src, input logic [7:0] d, input bit first, input bit err);
      exp_q.push_back('{gid: 2'(src), data: d, first: first, err: err});
   endfunction

   // returns whether the first payload byte is the first byte of the frame on the wire
   function automatic bit exp_start(input int src);
      if (H != 0) begin
         exp_q.push_back('{gid: 2'(src), data: 8'hA0 | 8'(src), first: 1'b1, err: 1'b0});
         return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic run(input int limit);
      for (int k = 0; k < limit && obs_q.size() < exp_q.size(); k++) step(1'b1, 1'b0);
      repeat (4) step(1'b1, 1'b0);
   endtask

   task automatic do_reset();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      exp_q.delete();
      obs_q.delete();
      busy_tr.delete();
      err_total = 0;
   endtask

   task automatic check_stream(input string name, input bit gap_chk);
      int n, gap_want, gap_got;
      tests++;
      if (obs_q.size() != exp_q.size()) begin
         failed++;
         $display("FAIL %s beat count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         tests++;
         if (obs_q[k].data !== exp_q[k].data || obs_q[k].gid !== exp_q[k].gid || obs_q[k].err !== exp_q[k].err) begin
            failed++;
            $display("FAIL %s beat %0d: got src %0d data 0x%02h err %0b, expected src %0d data 0x%02h err %0b",
                     name, k, obs_q[k].gid, obs_q[k].data, obs_q[k].err, exp_q[k].gid, exp_q[k].data, exp_q[k].err);
         end
         if (gap_chk && k > 0) begin
            gap_want = exp_q[k].first ? 2 : 1;
            gap_got  = obs_q[k].cyc - obs_q[k-1].cyc;
            tests++;
            if (gap_got != gap_want) begin
               failed++;
               $display("FAIL %s gap before beat %0d: got %0d cycles, expected %0d", name, k, gap_got, gap_want);
            end
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      tests += 6;
      if (m_tvalid !== 1'b0) begin failed++; $display("FAIL reset m_tvalid: got %b, expected 0", m_tvalid); end
      if (m_tdata !== 8'h00) begin failed++; $display("FAIL reset m_tdata: got 0x%02h, expected 0x00", m_tdata); end
      if (s_tready !== 3'b000) begin failed++; $display("FAIL reset s_tready: got %b, expected 000", s_tready); end
      if (busy !== 1'b0) begin failed++; $display("FAIL reset busy: got %b, expected 0", busy); end
      if (grant_id !== 2'd0) begin failed++; $display("FAIL reset grant_id: got %0d, expected 0", grant_id); end
      if (err_overlen !== 1'b0) begin failed++; $display("FAIL reset err_overlen: got %b, expected 0", err_overlen); end
   endtask

   task automatic test_single();
      bit f;
      int c0;
      logic b_exp, b_got;
      do_reset();
      load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
      f = exp_start(0);
      exp_beat(0, 8'h11, f, 1'b0); exp_beat(0, 8'h22, 1'b0, 1'b0); exp_beat(0, 8'h33, 1'b0, 1'b0);
      c0 = cyc + 1;
      run(30);
      tests++;
      if (obs_q.size() == 0 || obs_q[0].cyc != c0 + 1) begin
         failed++;
         $display("FAIL single latency: got first beat at cycle %0d, expected %0d",
                  (obs_q.size() > 0) ? obs_q[0].cyc : -1, c0 + 1);
      end
      for (int k = 0; k <= 4 + H; k++) begin
         b_exp = (k >= 1 && k <= 3 + H);
         b_got = (k < busy_tr.size()) ? busy_tr[k] : 1'bx;
         tests++;
         if (b_got !== b_exp) begin
            failed++;
            $display("FAIL single busy cycle %0d: got %b, expected %b", k, b_got, b_exp);
         end
      end
      check_stream("single", 1'b1);
   endtask

   task automatic test_round_robin();
      bit f;
      do_reset();
      for (int s = 0; s < NS; s++) begin
         load(s, 8'(s*16 + 1), 1'b0); load(s, 8'(s*16 + 2), 1'b1);
         load(s, 8'(s*16 + 3), 1'b0); load(s, 8'(s*16 + 4), 1'b1);
      end
      for (int rep = 0; rep < 2; rep++) begin
         for (int s = 0; s < NS; s++) begin
            f = exp_start(s);
            exp_beat(s, 8'(s*16 + 1 + rep*2), f, 1'b0);
            exp_beat(s, 8'(s*16 + 2 + rep*2), 1'b0, 1'b0);
         end
      end
      run(80);
      check_stream("round_robin", 1'b1);
   endtask

   task automatic test_backpressure();
      bit f, in_pass;
      int acc;
      logic rdy;
      logic [NS-1:0] rdy_exp;
      do_reset();
      for (int b = 1; b <= 4; b++) load(1, 8'hB0 + 8'(b), b == 4);
      f = exp_start(1);
      exp_beat(1, 8'hB1, f, 1'b0); exp_beat(1, 8'hB2, 1'b0, 1'b0);
      exp_beat(1, 8'hB3, 1'b0, 1'b0); exp_beat(1, 8'hB4, 1'b0, 1'b0);
      acc = 0;
      for (int k = 0; k < 14; k++) begin
         rdy = (k % 2 == 1);
         step(rdy, 1'b0);
         in_pass = (k >= 1 + H) && (acc < 4);
         rdy_exp = {1'b0, in_pass & rdy, 1'b0};
         tests++;
         if (s_tready !== rdy_exp) begin
            failed++;
            $display("FAIL backpressure s_tready cycle %0d: got %b, expected %b", k, s_tready, rdy_exp);
         end
         if (in_pass && rdy) acc++;
      end
      check_stream("backpressure", 1'b0);
   endtask

   task automatic test_overlength();
      bit f;
      do_reset();
      for (int b = 1; b <= 6; b++) load(0, 8'(b), b == 6);
      load(1, 8'h81, 1'b0); load(1, 8'h82, 1'b1);
      f = exp_start(0);
      exp_beat(0, 8'h01, f, 1'b0); exp_beat(0, 8'h02, 1'b0, 1'b0);
      exp_beat(0, 8'h03, 1'b0, 1'b0); exp_beat(0, 8'h04, 1'b0, 1'b1);
      f = exp_start(1);
      exp_beat(1, 8'h81, f, 1'b0); exp_beat(1, 8'h82, 1'b0, 1'b0);
      f = exp_start(0);
      exp_beat(0, 8'h05, f, 1'b0); exp_beat(0, 8'h06, 1'b0, 1'b0);
      run(60);
      check_stream("overlength", 1'b1);
      tests++;
      if (err_total != 1) begin
         failed++;
         $display("FAIL overlength pulse count: got %0d, expected 1", err_total);
      end
   endtask

   task automatic test_header();
      bit f;
      do_reset();
      load(2, 8'h7F, 1'b1);
      f = exp_start(2);
      exp_beat(2, 8'h7F, f, 1'b0);
      run(20);
      check_stream("header", 1'b1);
      tests++;
      if (grant_id !== 2'd2) begin
         failed++;
         $display("FAIL header grant_id: got %0d, expected 2", grant_id);
      end
   endtask

   task automatic test_reset_mid();
      bit f;
      do_reset();
      for (int b = 1; b <= 5; b++) load(0, 8'h50 + 8'(b), b == 5);
      load(1, 8'h91, 1'b1);
      f = exp_start(0);
      exp_beat(0, 8'h51, f, 1'b0); exp_beat(0, 8'h52, 1'b0, 1'b0);
      for (int k = 0; k < 20 && obs_q.size() < 2 + H; k++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      src_q[0].delete();
      load(0, 8'h61, 1'b1);
      step(1'b1, 1'b0);
      tests += 6;
      if (m_tvalid !== 1'b0) begin failed++; $display("FAIL rst_mid m_tvalid: got %b, expected 0", m_tvalid); end
      if (m_tdata !== 8'h00) begin failed++; $display("FAIL rst_mid m_tdata: got 0x%02h, expected 0x00", m_tdata); end
      if (s_tready !== 3'b000) begin failed++; $display("FAIL rst_mid s_tready: got %b, expected 000", s_tready); end
      if (busy !== 1'b0) begin failed++; $display("FAIL rst_mid busy: got %b, expected 0", busy); end
      if (grant_id !== 2'd0) begin failed++; $display("FAIL rst_mid grant_id: got %0d, expected 0", grant_id); end
      if (err_overlen !== 1'b0) begin failed++; $display("FAIL rst_mid err_overlen: got %b, expected 0", err_overlen); end
      f = exp_start(0);
      exp_beat(0, 8'h61, f, 1'b0);
      f = exp_start(1);
      exp_beat(1, 8'h91, f, 1'b0);
      run(30);
      check_stream("rst_mid", 1'b0);
   endtask

   initial begin
      tests = 0; failed = 0; cyc = 0; err_total = 0; fire = '0;
      rst = 1'b1; m_tready = 1'b0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_overlength();
      test_header();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
